// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_ctrl_if : decode/EX-side bundle for the multiply/divide unit      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface mdu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_ctrl : radix-2 MULT/MULTU/DIV/DIVU sequencer owning HI/LO         |
// | Option macro MDU_DIVZERO_FAST_EN: divide by zero bypasses CALC/FIXUP  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_ctrl_if.slave bus
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_div;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_divzero;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_signed = ~bus.op[0];
  assign w_a_mag  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply keeps {acc,q} as the product; divide keeps acc=remainder, q=quotient.
  assign w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_div_sh   = {r_acc, r_q[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_ge   = ~w_div_diff[WIDTH];

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (r_div) begin
      if (r_divzero) begin
        w_res_hi = r_a_raw;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_rem ? -r_acc : r_acc;
        w_res_lo = r_neg_res ? -r_q : r_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div     <= 1'b0;
      r_a_raw   <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_divzero <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      // MTHI/MTLO first so a same-edge completion write takes priority.
      if (bus.hi_we) r_hi <= bus.wdata;
      if (bus.lo_we) r_lo <= bus.wdata;

      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            r_div     <= bus.op[1];
            r_a_raw   <= bus.a;
            r_acc     <= '0;
            r_q       <= bus.op[1] ? w_a_mag : w_b_mag;
            r_b       <= bus.op[1] ? w_b_mag : w_a_mag;
            r_neg_res <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_rem <= w_signed & bus.a[WIDTH-1];
            r_divzero <= bus.op[1] & (bus.b == '0);
            r_cnt     <= c_CNT_W'(WIDTH);
`ifdef MDU_DIVZERO_FAST_EN
            if (bus.op[1] && (bus.b == '0)) begin
              r_hi    <= bus.a;
              r_lo    <= '1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
`else
            r_busy  <= 1'b1;
            r_state <= S_CALC;
`endif
          end
        end

        S_CALC: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (r_div) begin
              r_acc <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], w_div_ge};
            end else begin
              r_acc <= w_mul_sum[WIDTH:1];
              r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
            end
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (r_cnt == c_CNT_W'(1)) r_state <= S_FIXUP;
          end
        end

        S_FIXUP: begin
          r_busy <= 1'b0;
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mdu_ctrl : directed vector table plus flush/collision/reset cases  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_mdu_ctrl;

`ifdef MDU_DIVZERO_FAST_EN
  localparam bit c_FAST = 1'b1;
`else
  localparam bit c_FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_ctrl_if #(.WIDTH(32)) bus ();
  mdu_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Launches one op, then watches up to 60 cycles; optional MTHI / stray start injections.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hiwe_k, input int start_k,
                        output int lat, output int busy_cnt, output int done_cnt);
    lat = 0; busy_cnt = 0; done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      busy_cnt += int'(bus.busy);
      if (bus.done) begin
        done_cnt++;
        if (lat == 0) lat = k;
      end
      if (k == hiwe_k) begin bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF; end
      if (k == start_k) begin bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; end
      if (lat != 0 && k >= lat + 3) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, dc, exp_lat, exp_busy;
    bit fast_dz;

    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[6]  = '{2'b10, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[9]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
    vecs[12] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    #12;
    check("reset_hi",   bus.hi, 32'h0);
    check("reset_lo",   bus.lo, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // start together with flush in IDLE must not launch
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("start_flush_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    check("start_flush_busy2", 32'(bus.busy), 32'h0);
    check("start_flush_done",  32'(bus.done), 32'h0);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, lat, bc, dc);
      fast_dz  = c_FAST && vecs[i].op[1] && (vecs[i].b == 32'h0);
      exp_lat  = fast_dz ? 1 : 34;
      exp_busy = fast_dz ? 0 : 33;
      check($sformatf("v%0d_hi", i),      bus.hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i),      bus.lo, vecs[i].lo);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(exp_busy));
      check($sformatf("v%0d_done_pulses", i), 32'(dc), 32'd1);
    end

    // MTHI/MTLO preload, then flush MULT in CALC cycle 10
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mthi_idle", bus.hi, 32'h1234);
    check("mtlo_idle", bus.lo, 32'h5678);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd4;
    dc = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      dc += int'(bus.done);
    end
    check("flush_pre_busy", 32'(bus.busy), 32'h1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    dc += int'(bus.done);
    check("flush_busy",  32'(bus.busy), 32'h0);
    check("flush_done",  32'(dc), 32'h0);
    check("flush_hi",    bus.hi, 32'h1234);
    check("flush_lo",    bus.lo, 32'h5678);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_busy", 32'(bus.busy), 32'h1);
    lat = 0;
    for (int k = 2; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done) begin lat = k; break; end
    end
    check("restart_latency", 32'(lat), 32'd34);
    check("restart_hi", bus.hi, 32'h0);
    check("restart_lo", bus.lo, 32'd12);

    // stray start while busy, MTHI colliding with the completion write
    run_op(2'b01, 32'd6, 32'd7, 33, 5, lat, bc, dc);
    check("collide_latency", 32'(lat), 32'd34);
    check("collide_hi",      bus.hi, 32'h0);
    check("collide_lo",      bus.lo, 32'd42);
    check("collide_busy_cycles", 32'(bc), 32'd33);
    check("collide_done_pulses", 32'(dc), 32'd1);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hFFFFFFFD; bus.b = 32'd5;
    repeat (6) @(negedge clk);
    bus.start = 1'b0;
    check("pre_rst_busy", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_hi",   bus.hi, 32'h0);
    check("async_rst_lo",   bus.lo, 32'h0);
    check("async_rst_busy", 32'(bus.busy), 32'h0);
    check("async_rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b01, 32'd2, 32'd3, 0, 0, lat, bc, dc);
    check("post_rst_lo",      bus.lo, 32'd6);
    check("post_rst_latency", 32'(lat), 32'd34);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
